// File: rtl/drp_slave_regs.sv
// drp_slave_regs: DRP target holding a bank of 16-bit registers.
// Every accepted read or write is answered with a one-cycle drp_rdy after a
// fixed latency. Requests that arrive while a transaction is in flight are
// dropped and flagged on collision.
// Optional build macro DRP_SLAVE_JITTER_EN: when defined, an LFSR adds 0..7
// extra cycles of latency to each accepted transaction.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for drp_en; accepts a new transaction
// ST_WAIT | latency countdown, request latched, busy
// ST_RESP | drp_rdy high for this single cycle, then back to ST_IDLE

module drp_slave_regs #(
  parameter int          ADDR_WIDTH     = 10,
  parameter int          REG_ADDR_WIDTH = 4,
  parameter int          RD_LATENCY     = 2,
  parameter int          WR_LATENCY     = 1,
  parameter logic [15:0] RESET_VALUE    = 16'h0000,
  parameter logic [15:0] UNMAPPED_DATA  = 16'hDEAD
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [ADDR_WIDTH-1:0]                drp_addr,
  input  logic [15:0]                          drp_di,
  output logic [15:0]                          drp_do,
  input  logic                                 drp_en,
  input  logic                                 drp_we,
  output logic                                 drp_rdy,
  output logic [16*(2**REG_ADDR_WIDTH)-1:0]    regs_out,
  output logic                                 busy,
  output logic                                 collision
);

  localparam int         NUM_REGS = 2**REG_ADDR_WIDTH;
  // Counter is 5 bits wide so a 15-cycle latency plus 7 jitter cycles fits.
  localparam logic [4:0] RD_LOAD  = 5'(RD_LATENCY - 1);
  localparam logic [4:0] WR_LOAD  = 5'(WR_LATENCY - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]                state;
  logic [4:0]                cnt;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [15:0]               di_q;
  logic                      we_q;
  logic [15:0]               regs_mem [NUM_REGS];
  logic [2:0]                extra;

  logic                      accept;
  logic                      enter_resp;
  logic [4:0]                load_val;
  logic [ADDR_WIDTH-1:0]     cur_addr;
  logic [15:0]               cur_di;
  logic                      cur_we;
  logic [REG_ADDR_WIDTH-1:0] cur_idx;
  logic                      cur_mapped;

`ifdef DRP_SLAVE_JITTER_EN
  logic [15:0] lfsr;

  // Galois LFSR (x^16+x^14+x^13+x^11+1), stepped once per accepted request;
  // the pre-step value sets the extra latency of that request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 16'hACE1;
    end else if (accept) begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign extra = lfsr[2:0];
`else
  assign extra = 3'd0;
`endif

  // Request decode; a zero-latency load jumps straight to ST_RESP, so the
  // register access must use the live bus rather than the latched copy.
  always_comb begin
    accept     = (state == ST_IDLE) && drp_en;
    cur_addr   = (state == ST_IDLE) ? drp_addr : addr_q;
    cur_di     = (state == ST_IDLE) ? drp_di   : di_q;
    cur_we     = (state == ST_IDLE) ? drp_we   : we_q;
    cur_idx    = cur_addr[REG_ADDR_WIDTH-1:0];
    cur_mapped = (cur_addr >> REG_ADDR_WIDTH) == '0;
    load_val   = (drp_we ? WR_LOAD : RD_LOAD) + {2'b00, extra};
    enter_resp = (accept && (load_val == 5'd0)) ||
                 ((state == ST_WAIT) && (cnt == 5'd1));
  end

  assign drp_rdy   = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);
  assign collision = drp_en && busy;

  // Transaction sequencing and latency down-counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= 5'd0;
      addr_q <= '0;
      di_q   <= 16'h0000;
      we_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (drp_en) begin
            addr_q <= drp_addr;
            di_q   <= drp_di;
            we_q   <= drp_we;
            cnt    <= load_val;
            state  <= (load_val == 5'd0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            state <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Register write and read-data capture on the edge entering ST_RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drp_do <= 16'h0000;
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_mem[k] <= RESET_VALUE;
      end
    end else if (enter_resp) begin
      if (cur_we) begin
        if (cur_mapped) begin
          regs_mem[cur_idx] <= cur_di;
        end
      end else begin
        drp_do <= cur_mapped ? regs_mem[cur_idx] : UNMAPPED_DATA;
      end
    end
  end

  // Flatten the register bank onto regs_out.
  always_comb begin
    regs_out = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      regs_out[k*16 +: 16] = regs_mem[k];
    end
  end

endmodule

// File: tb/tb_drp_slave_regs.sv
// Directed bench for drp_slave_regs. Three instances share one DRP bus:
// u_dut0 uses default latencies, u_dut1 has RD_LATENCY = 4, u_dut2 has
// WR_LATENCY = 3. Every section starts from reset so instances stay aligned.

module tb_drp_slave_regs;

   logic        clk;
   logic        rst_n;
   logic [9:0]  drp_addr;
   logic [15:0] drp_di;
   logic        drp_en;
   logic        drp_we;

   logic [15:0]  do_v   [3];
   logic [255:0] regs_v [3];
   logic [2:0]   rdy_v;
   logic [2:0]   busy_v;
   logic [2:0]   coll_v;

   int n_vec;
   int n_err;
   int n_rdy;
   int n_coll;
   logic [15:0] m_lfsr;

   drp_slave_regs u_dut0 (
      .clk(clk), .rst_n(rst_n), .drp_addr(drp_addr), .drp_di(drp_di),
      .drp_do(do_v[0]), .drp_en(drp_en), .drp_we(drp_we), .drp_rdy(rdy_v[0]),
      .regs_out(regs_v[0]), .busy(busy_v[0]), .collision(coll_v[0])
   );

   drp_slave_regs #(.RD_LATENCY(4)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .drp_addr(drp_addr), .drp_di(drp_di),
      .drp_do(do_v[1]), .drp_en(drp_en), .drp_we(drp_we), .drp_rdy(rdy_v[1]),
      .regs_out(regs_v[1]), .busy(busy_v[1]), .collision(coll_v[1])
   );

   drp_slave_regs #(.WR_LATENCY(3)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .drp_addr(drp_addr), .drp_di(drp_di),
      .drp_do(do_v[2]), .drp_en(drp_en), .drp_we(drp_we), .drp_rdy(rdy_v[2]),
      .regs_out(regs_v[2]), .busy(busy_v[2]), .collision(coll_v[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs,
                      input logic [255:0] exp_v);
      n_vec++;
      if (obs !== exp_v) begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Extra latency expected for the next accepted transaction.
   function automatic int next_extra();
`ifdef DRP_SLAVE_JITTER_EN
      int e;
      e = int'(m_lfsr[2:0]);
      m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
      return e;
`else
      return 0;
`endif
   endfunction

   task automatic set_bus(input logic en, input logic we, input logic [9:0] a,
                          input logic [15:0] d);
      drp_en   = en;
      drp_we   = we;
      drp_addr = a;
      drp_di   = d;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      set_bus(1'b0, 1'b0, 10'h000, 16'h0000);
      repeat (2) @(posedge clk);
      #1;
      rst_n  = 1'b1;
      m_lfsr = 16'hACE1;
   endtask

   // One transaction on the shared bus, watching instance inst; returns at
   // the falling edge inside its drp_rdy cycle.
   task automatic txn(input string tag, input int inst, input logic we,
                      input logic [9:0] a, input logic [15:0] d,
                      input int base_lat);
      int  lat;
      int  exp_lat;
      bit  got;
      exp_lat = base_lat + next_extra();
      set_bus(1'b1, we, a, d);
      @(posedge clk);
      #1;
      set_bus(1'b0, 1'b0, 10'h000, 16'h0000);
      lat = 1;
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
         @(negedge clk);
         if (coll_v[inst]) n_coll++;
         if (rdy_v[inst]) begin
            got = 1'b1;
         end else begin
            lat++;
            @(posedge clk);
            #1;
         end
      end
      if (got) n_rdy++;
      chk(tag, lat, exp_lat);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int rdy_cnt;
      int rdy_at;
      int ext;
      int exp_j [4];
      n_vec  = 0;
      n_err  = 0;
      n_rdy  = 0;
      n_coll = 0;
      m_lfsr = 16'hACE1;
      rst_n  = 1'b0;
      set_bus(1'b0, 1'b0, 10'h000, 16'h0000);

      // Reset state
      do_reset();
      @(negedge clk);
      chk("rst_rdy", rdy_v[0], 1'b0);
      chk("rst_do", do_v[0], 16'h0000);
      chk("rst_busy", busy_v[0], 1'b0);
      chk("rst_coll", coll_v[0], 1'b0);
      chk("rst_regs", regs_v[0], {256{1'b0}});
      next_cycle();

      // Write then read back
      txn("wr3_lat", 0, 1'b1, 10'h003, 16'h1234, 1);
      chk("wr3_regs", regs_v[0][63:48], 16'h1234);
      next_cycle();
      txn("rd3_lat", 0, 1'b0, 10'h003, 16'h0000, 2);
      chk("rd3_do", do_v[0], 16'h1234);
      repeat (3) next_cycle();
      @(negedge clk);
      chk("rd3_do_hold", do_v[0], 16'h1234);
      next_cycle();
      txn("wr5_lat", 0, 1'b1, 10'h005, 16'h7777, 1);
      chk("wr5_do_unchanged", do_v[0], 16'h1234);
      chk("wr5_regs", regs_v[0][95:80], 16'h7777);

      // Unmapped addresses and top-of-map boundary
      do_reset();
      txn("wr010_lat", 0, 1'b1, 10'h010, 16'hBEEF, 1);
      chk("wr010_regs", regs_v[0], {256{1'b0}});
      next_cycle();
      txn("rd3ff_lat", 0, 1'b0, 10'h3FF, 16'h0000, 2);
      chk("rd3ff_do", do_v[0], 16'hDEAD);
      next_cycle();
      txn("wr00f_lat", 0, 1'b1, 10'h00F, 16'hCAFE, 1);
      chk("wr00f_regs", regs_v[0][255:240], 16'hCAFE);
      next_cycle();
      txn("rd00f_lat", 0, 1'b0, 10'h00F, 16'h0000, 2);
      chk("rd00f_do", do_v[0], 16'hCAFE);
      next_cycle();
      txn("rd01f_lat", 0, 1'b0, 10'h01F, 16'h0000, 2);
      chk("rd01f_do", do_v[0], 16'hDEAD);

      // Collision against u_dut1 (RD_LATENCY = 4)
      do_reset();
      ext     = next_extra();
      rdy_cnt = 0;
      rdy_at  = -1;
      for (int c = 0; c <= 14; c++) begin
         if (c == 0)      set_bus(1'b1, 1'b0, 10'h000, 16'h0000);
         else if (c == 2) set_bus(1'b1, 1'b1, 10'h001, 16'hFFFF);
         else             set_bus(1'b0, 1'b0, 10'h000, 16'h0000);
         @(negedge clk);
         if (c == 1) chk("coll_quiet", coll_v[1], 1'b0);
         if (c == 2) chk("coll_pulse", coll_v[1], 1'b1);
         if (rdy_v[1]) begin
            rdy_cnt++;
            rdy_at = c;
         end
         next_cycle();
      end
      chk("coll_rdy_count", rdy_cnt, 1);
      chk("coll_rdy_cycle", rdy_at, 4 + ext);
      chk("coll_reg1", regs_v[1][31:16], 16'h0000);

      // Back-to-back writes on u_dut0
      do_reset();
      n_rdy  = 0;
      n_coll = 0;
      for (int i = 0; i < 8; i++) begin
         txn("b2b_lat", 0, 1'b1, 10'(i), 16'(i) * 16'h1111, 1);
         next_cycle();
      end
      chk("b2b_rdy_count", n_rdy, 8);
      chk("b2b_coll_count", n_coll, 0);
      for (int i = 0; i < 8; i++) begin
         chk("b2b_val", regs_v[0][i*16 +: 16], 16'(i) * 16'h1111);
      end

      // Reset in the middle of a u_dut2 write (WR_LATENCY = 3)
      do_reset();
      set_bus(1'b1, 1'b1, 10'h002, 16'h5A5A);
      next_cycle();
      set_bus(1'b0, 1'b0, 10'h000, 16'h0000);
      rst_n   = 1'b0;
      rdy_cnt = 0;
      @(negedge clk);
      chk("midrst_busy", busy_v[2], 1'b0);
      for (int c = 0; c < 6; c++) begin
         next_cycle();
         if (c == 1) rst_n = 1'b1;
         @(negedge clk);
         if (rdy_v[2]) rdy_cnt++;
      end
      chk("midrst_no_rdy", rdy_cnt, 0);
      chk("midrst_reg2", regs_v[2][47:32], 16'h0000);
      chk("midrst_busy_after", busy_v[2], 1'b0);
      m_lfsr = 16'hACE1;
      next_cycle();
      txn("midrst_next_lat", 2, 1'b1, 10'h002, 16'h0F0F, 3);
      chk("midrst_next_reg2", regs_v[2][47:32], 16'h0F0F);

`ifdef DRP_SLAVE_JITTER_EN
      // Jitter: seed 16'hACE1 gives extra = 1, 0, 0, 4
      do_reset();
      exp_j = '{2, 1, 1, 5};
      for (int i = 0; i < 4; i++) begin
         txn("jit_lat_model", 0, 1'b1, 10'(i), 16'h1000 + 16'(i), 1);
         chk("jit_val", regs_v[0][i*16 +: 16], 16'h1000 + 16'(i));
         next_cycle();
      end
      do_reset();
      for (int i = 0; i < 4; i++) begin
         rdy_cnt = 0;
         set_bus(1'b1, 1'b1, 10'(i), 16'h2000);
         for (int c = 1; c <= 12 && rdy_cnt == 0; c++) begin
            next_cycle();
            set_bus(1'b0, 1'b0, 10'h000, 16'h0000);
            @(negedge clk);
            if (rdy_v[0]) rdy_cnt = c;
         end
         chk("jit_lat_table", rdy_cnt, exp_j[i]);
         next_cycle();
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/drp_slave_regs.md
Name: drp_slave_regs

Overview:
- DRP responder (target) block: the far end of the DRP initiator used by the XFCP DRP/GTY access modules.
- Holds a bank of 16-bit registers behind a DRP port and answers each DRP read or write with a single-cycle drp_rdy after a programmable latency.
- Used as a stand-in transceiver or common block in simulation and loopback bring-up.
- Also used as a generic DRP-mapped control register file inside user logic.

Parameters:
- ADDR_WIDTH, 10, width of drp_addr.
- REG_ADDR_WIDTH, 4, implemented registers = 2**REG_ADDR_WIDTH at addresses 0..2**REG_ADDR_WIDTH-1; must be ≤ ADDR_WIDTH.
- RD_LATENCY, 2, cycles from accepted read to drp_rdy; range 1..15.
- WR_LATENCY, 1, cycles from accepted write to drp_rdy; range 1..15.
- RESET_VALUE, 16'h0000, reset contents of every register.
- UNMAPPED_DATA, 16'hDEAD, read data returned for addresses ≥ 2**REG_ADDR_WIDTH.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- drp_addr, input, ADDR_WIDTH, DRP address.
- drp_di, input, 16, write data from the initiator.
- drp_do, output, 16, read data to the initiator.
- drp_en, input, 1, transaction strobe (one cycle).
- drp_we, input, 1, write qualifier, sampled with drp_en.
- drp_rdy, output, 1, one-cycle completion pulse.
- regs_out, output, 16*2**REG_ADDR_WIDTH, live register contents; register k is at [k*16 +: 16].
- busy, output, 1, high from the accept cycle through the drp_rdy cycle.
- collision, output, 1, one-cycle pulse when drp_en arrives while busy.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = IDLE; drp_rdy = 0, drp_do = 0, busy = 0, collision = 0.
  - All registers = RESET_VALUE; latency counter = 0.
- States: IDLE, WAIT, RESP.
- IDLE:
  - On drp_en = 1, latch addr, di and we.
  - Load the counter with (we ? WR_LATENCY : RD_LATENCY) - 1.
  - If the counter value is 0 go to RESP, else go to WAIT. busy goes high next cycle.
- WAIT: decrement the counter each cycle; go to RESP when it reaches 0.
- RESP:
  - drp_rdy = 1 for exactly this cycle, then return to IDLE.
  - drp_en sampled in this cycle is a collision (the new request is not accepted).
- Latency: drp_en asserted in cycle T gives drp_rdy in cycle T+LAT exactly.
- Reads:
  - Register contents are sampled at the RESP transition.
  - drp_do is updated in the drp_rdy cycle and holds its value until the next read completes. Writes do not change drp_do.
  - Unmapped address returns UNMAPPED_DATA.
- Writes:
  - The register updates on the clock edge that raises drp_rdy, so regs_out shows the new value in the drp_rdy cycle.
  - A write to an unmapped address is dropped, but drp_rdy is still returned.
- Address decode:
  - A mapped register is selected by drp_addr[REG_ADDR_WIDTH-1:0] only when the upper bits are zero.
- drp_en while busy (WAIT or RESP):
  - Request ignored; collision pulses in the same cycle.
  - The in-flight transaction completes unchanged; no queuing.
- Back-to-back: drp_en in the cycle after drp_rdy is accepted normally (minimum period LAT+1).
- Reset mid-transaction: the transaction is aborted, no drp_rdy is issued, and a pending write is lost.
- drp_we without drp_en has no effect.

Optional Feature:
- Macro: DRP_SLAVE_JITTER_EN.
- When defined:
  - A 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1, reset seed 16'hACE1) advances once per accepted transaction.
  - lfsr[2:0] (0..7) extra cycles are added to that transaction's latency, so drp_rdy lands at T+LAT+extra.
  - busy covers the extra cycles, and collisions are detected throughout them.
- When undefined: latency is fixed and the LFSR is not built.

Test Plan:
- Write and read back:
  - Reset, then write 16'h1234 to addr 3. Expect drp_rdy exactly 1 cycle after en, and regs_out[63:48] = 16'h1234 in that cycle.
  - Read addr 3. Expect drp_rdy 2 cycles after en with drp_do = 16'h1234, and drp_do holds afterwards.
- Unmapped address:
  - Write 16'hBEEF to addr 10'h010; every regs_out word stays 0.
  - Read addr 10'h3FF; expect drp_do = 16'hDEAD.
- Collision:
  - Read addr 0 with RD_LATENCY = 4; pulse drp_en (write, addr 1) 2 cycles later.
  - Expect collision = 1 in that cycle and reg 1 unchanged.
  - Expect the read's drp_rdy at T+4 and exactly one drp_rdy in total.
- Back-to-back:
  - Issue 8 writes, each drp_en one cycle after the previous drp_rdy, to addrs 0..7 with data = addr*16'h1111.
  - Expect 8 drp_rdy pulses, no collision, and all 8 values correct.
- Reset mid-operation:
  - Write 16'h5A5A to addr 2 with WR_LATENCY = 3; drop rst_n 1 cycle after en.
  - Expect no drp_rdy, reg 2 = RESET_VALUE, busy = 0, and the next transaction is accepted normally.
- Jitter (DRP_SLAVE_JITTER_EN defined, WR_LATENCY = 1):
  - Issue 4 writes.
  - Expect each latency = 1 + the lfsr[2:0] sequence derived from seed 16'hACE1, and the bench model matches every drp_rdy cycle.
